// File: rtl/board_frame_loader.sv
// Word-stream deserialiser: assembles NWORDS words into a board image
// plus header flags, committed atomically with marker and timeout checks.
module board_frame_loader #(
    parameter int BOARD_BITS = 722,
    parameter int FLAG_BITS  = 1,
    parameter int WORD_W     = 32,
    parameter int NWORDS     = 23,
    parameter int USE_LAST   = 1,
    parameter int TIMEOUT    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    input  logic [WORD_W-1:0]             s_data,
    input  logic                          s_last,
    output logic                          s_ready,
    input  logic                          hold,
    output logic [BOARD_BITS-1:0]         board,
    output logic [FLAG_BITS-1:0]          flags,
    output logic                          frame_start,
    output logic                          frame_done,
    output logic                          frame_err,
    output logic                          busy,
    output logic [$clog2(NWORDS+1)-1:0]   word_cnt
);

    localparam int SW = NWORDS * WORD_W;
    localparam int CW = $clog2(NWORDS + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);
    localparam logic [TW-1:0] T_LIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    generate
        if (SW < BOARD_BITS + FLAG_BITS) begin : g_size_check
            $error("NWORDS*WORD_W too small for BOARD_BITS+FLAG_BITS");
        end
    endgenerate

    typedef enum logic {IDLE, LOAD} state_t;

    state_t          state;
    logic [SW-1:0]   shadow;
    logic [SW-1:0]   shifted;
    logic [TW-1:0]   tcnt;
    logic            accept;
    logic            is_final;
    logic            bad_mark;
    logic            expire;

    assign s_ready  = !hold && !rst;
    assign accept   = s_valid && s_ready;
    assign busy     = (state == LOAD);

    // Word 0 ends up most significant once every word has been shifted in.
    assign shifted  = (shadow << WORD_W) | SW'(s_data);
    assign is_final = (word_cnt == LAST_IDX);
    assign bad_mark = (USE_LAST != 0) && (s_last != is_final);
    assign expire   = (TIMEOUT != 0) && (state == LOAD) && !accept
                      && (tcnt == T_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shadow      <= '0;
            tcnt        <= '0;
            word_cnt    <= '0;
            board       <= '0;
            flags       <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            if (accept) begin
                tcnt <= '0;
                if (bad_mark) begin
                    frame_err <= 1'b1;
                    word_cnt  <= '0;
                    state     <= IDLE;
                end else if (is_final) begin
                    board       <= shifted[BOARD_BITS-1:0];
                    flags       <= shifted[BOARD_BITS+FLAG_BITS-1:BOARD_BITS];
                    frame_done  <= 1'b1;
                    frame_start <= (state == IDLE);
                    word_cnt    <= '0;
                    state       <= IDLE;
                end else begin
                    shadow      <= shifted;
                    frame_start <= (state == IDLE);
                    word_cnt    <= word_cnt + CW'(1);
                    state       <= LOAD;
                end
            end else if (expire) begin
                frame_err <= 1'b1;
                word_cnt  <= '0;
                tcnt      <= '0;
                state     <= IDLE;
            end else if (state == LOAD && TIMEOUT != 0) begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_board_frame_loader.sv
// Randomised bench for board_frame_loader against a frame-level
// reference model built from word queues and plain concatenation.
module tb_board_frame_loader;

    localparam int BB = 722;
    localparam int NW = 23;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [31:0]   s_data;
    logic          s_last;
    logic          s_ready;
    logic          hold;
    logic [BB-1:0] board;
    logic [0:0]    flags;
    logic          frame_start;
    logic          frame_done;
    logic          frame_err;
    logic          busy;
    logic [4:0]    word_cnt;

    board_frame_loader #(
        .BOARD_BITS(BB), .FLAG_BITS(1), .WORD_W(32),
        .NWORDS(NW), .USE_LAST(1), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .hold(hold),
        .board(board), .flags(flags), .frame_start(frame_start),
        .frame_done(frame_done), .frame_err(frame_err),
        .busy(busy), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference state: words of the frame in progress, idle run length,
    // last committed image and the pulses expected after this edge.
    logic [31:0]   q[$];
    int            idle = 0;
    logic [BB-1:0] m_board = '0;
    logic          m_flag = 1'b0;
    bit            m_start, m_done, m_err;

    task automatic check(string tag, logic [767:0] got, logic [767:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void step(bit v, logic [31:0] d, bit l, bit h, bit r);
        logic [767:0] img;
        int n;
        bit fin;
        m_start = 0;
        m_done  = 0;
        m_err   = 0;
        if (r) begin
            q.delete();
            idle    = 0;
            m_board = '0;
            m_flag  = 1'b0;
            return;
        end
        n = q.size();
        if (v && !h) begin
            idle = 0;
            fin  = (n == NW - 1);
            if (l != fin) begin
                m_err = 1;
                q.delete();
            end else if (fin) begin
                img = '0;
                foreach (q[i]) img = (img << 32) | 768'(q[i]);
                img     = (img << 32) | 768'(d);
                m_board = img[BB-1:0];
                m_flag  = img[BB];
                m_done  = 1;
                m_start = (n == 0);
                q.delete();
            end else begin
                q.push_back(d);
                m_start = (n == 0);
            end
        end else if (n > 0) begin
            idle++;
            if (idle == TO) begin
                m_err = 1;
                idle  = 0;
                q.delete();
            end
        end
    endfunction

    task automatic cycle(bit v, logic [31:0] d, bit l, bit h, bit r);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        hold    = h;
        rst     = r;
        #1 check("s_ready", 768'(s_ready), 768'(!h && !r));
        @(posedge clk);
        step(v, d, l, h, r);
        #1;
        check("frame_start", 768'(frame_start), 768'(m_start));
        check("frame_done", 768'(frame_done), 768'(m_done));
        check("frame_err", 768'(frame_err), 768'(m_err));
        check("busy", 768'(busy), 768'(q.size() > 0));
        check("word_cnt", 768'(word_cnt), 768'(q.size()));
        check("board", 768'(board), 768'(m_board));
        check("flags", 768'(flags), 768'(m_flag));
    endtask

    task automatic gap(int n);
        bit v;
        for (int k = 0; k < n; k++) begin
            v = 1'($urandom);
            cycle(v, $urandom, 1'($urandom), v ? 1'b1 : 1'($urandom), 1'b0);
        end
    endtask

    task automatic send_frame(int gmax);
        for (int i = 0; i < NW; i++) begin
            gap((gmax > 0) ? $urandom_range(gmax) : 0);
            cycle(1'b1, $urandom, i == NW - 1, 1'b0, 1'b0);
        end
    endtask

    logic [BB-1:0] a_board;
    bit            l;

    initial begin
        s_valid = 0; s_data = 0; s_last = 0; hold = 0; rst = 1;
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        check("reset_board", 768'(board), 768'(0));

        // Single frame, data = word index.
        for (int i = 0; i < NW; i++)
            cycle(1'b1, 32'(i), i == NW - 1, 1'b0, 1'b0);
        check("single_lsw", 768'(board[31:0]), 768'(22));
        check("single_word1", 768'(board[703:672]), 768'(1));
        check("single_flag", 768'(flags), 768'(0));

        // Double buffer: board holds A while B is partly loaded.
        send_frame(0);
        a_board = m_board;
        for (int i = 0; i < 10; i++) begin
            gap($urandom_range(3));
            cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        end
        check("dbuf_cnt", 768'(word_cnt), 768'(10));
        check("dbuf_busy", 768'(busy), 768'(1));
        check("dbuf_board", 768'(board), 768'(a_board));
        for (int i = 10; i < NW; i++)
            cycle(1'b1, $urandom, i == NW - 1, 1'b0, 1'b0);

        // Back-to-back frames with continuous valid.
        send_frame(0);
        send_frame(0);

        // Early marker on word 5.
        for (int i = 0; i < 6; i++)
            cycle(1'b1, $urandom, i == 5, 1'b0, 1'b0);
        check("early_cnt", 768'(word_cnt), 768'(0));
        send_frame(2);

        // Timeout after 3 words, then a word landing on the expiry cycle.
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("timeout_busy", 768'(busy), 768'(0));
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < TO - 1; i++) cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        check("expiry_err", 768'(frame_err), 768'(0));
        check("expiry_cnt", 768'(word_cnt), 768'(4));
        for (int i = 4; i < NW; i++)
            cycle(1'b1, $urandom, i == NW - 1, 1'b0, 1'b0);

        // Reset at word 12.
        for (int i = 0; i < 12; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
        check("rst_board", 768'(board), 768'(0));
        check("rst_cnt", 768'(word_cnt), 768'(0));
        send_frame(1);

        // Random traffic with occasional bad markers, timeouts and resets.
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < NW; i++) begin
                gap(($urandom_range(19) == 0) ? $urandom_range(12, 8)
                                              : $urandom_range(3));
                l = (i == NW - 1);
                if ($urandom_range(39) == 0) l = !l;
                cycle(1'b1, $urandom, l, 1'b0, $urandom_range(299) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
